// File: rtl/soc_system_key_irq_master_pkg.sv
// Shared types and constants for the key PIO interrupt master.
// Covers the state codes, the PIO register offsets and the bus command payload.
package soc_system_key_irq_master_pkg;

    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned KEY_W   = 4;
    localparam int unsigned SEQ_W   = 8;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned CNT_W   = 2;

    localparam logic [STATE_W-1:0] ST_INIT   = 3'd0;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd1;
    localparam logic [STATE_W-1:0] ST_RD_CAP = 3'd2;
    localparam logic [STATE_W-1:0] ST_WR_CLR = 3'd3;
    localparam logic [STATE_W-1:0] ST_RD_LVL = 3'd4;
    localparam logic [STATE_W-1:0] ST_EMIT   = 3'd5;

    localparam logic [ADDR_W-1:0] OFS_DATA = 2'd0;
    localparam logic [ADDR_W-1:0] OFS_MASK = 2'd2;
    localparam logic [ADDR_W-1:0] OFS_EDGE = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              chipselect;
        logic              write_n;
        logic [DATA_W-1:0] writedata;
    } avm_cmd_t;

    localparam avm_cmd_t CMD_IDLE = '{address: OFS_DATA, chipselect: 1'b0,
                                      write_n: 1'b1, writedata: '0};

    // Active access to the PIO at offset ofs; wr selects write vs read.
    function automatic avm_cmd_t avm_cmd(input logic [ADDR_W-1:0] ofs,
                                         input logic wr,
                                         input logic [DATA_W-1:0] data);
        avm_cmd_t c;
        c.address    = ofs;
        c.chipselect = 1'b1;
        c.write_n    = ~wr;
        c.writedata  = data;
        return c;
    endfunction

endpackage

// File: rtl/soc_system_key_irq_master_if.sv
// Avalon-MM master bus toward the key PIO plus the key-event valid/ready stream.
interface soc_system_key_irq_master_if;
    import soc_system_key_irq_master_pkg::*;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              irq;
    logic              evt_valid;
    logic              evt_ready;
    logic [KEY_W-1:0]  evt_edges;
    logic [KEY_W-1:0]  evt_level;
    logic [SEQ_W-1:0]  evt_seq;

    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata, irq,
        output evt_valid, evt_edges, evt_level, evt_seq,
        input  evt_ready
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata, irq,
        input  evt_valid, evt_edges, evt_level, evt_seq,
        output evt_ready
    );

endinterface

// File: rtl/soc_system_key_rd_timer.sv
// Read-latency down-counter: last_c marks the final cycle of a read phase.
// Reloads whenever no read phase is running, so consecutive phases start fresh.
module soc_system_key_rd_timer
    import soc_system_key_irq_master_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic last_c
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !run || cnt == '0) begin
            cnt <= CNT_LOAD;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last_c = run && (cnt == '0);

endmodule

// File: rtl/soc_system_key_irq_master.sv
// Services the key PIO interrupt: read edge capture, clear it, read levels and
// hand the result to a consumer as a sequenced valid/ready event.
module soc_system_key_irq_master
    import soc_system_key_irq_master_pkg::*;
#(
    parameter logic [KEY_W-1:0] IRQ_MASK = 4'hF,
    parameter int unsigned      RD_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    soc_system_key_irq_master_if.master  bus,
    output logic                         busy
);

    logic [STATE_W-1:0] state, state_next;
    avm_cmd_t           cmd_q, cmd_d;
    logic [KEY_W-1:0]   edges_q, edges_d;
    logic [KEY_W-1:0]   level_q, level_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic               valid_q, valid_d;
    logic               busy_d;
    logic               rd_run_c;
    logic               rd_last_c;
    logic [KEY_W-1:0]   cap_edges_c;
    logic               unused_rd_hi;

    assign rd_run_c     = (state == ST_RD_CAP) || (state == ST_RD_LVL);
    assign cap_edges_c  = bus.avm_readdata[KEY_W-1:0] & IRQ_MASK;
    assign unused_rd_hi = ^bus.avm_readdata[DATA_W-1:KEY_W];

    soc_system_key_rd_timer #(.RD_LAT(RD_LAT)) u_rd_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (rd_run_c),
        .last_c (rd_last_c)
    );

    // Next state, captured data and the registered bus command for the next state.
    always_comb begin
        state_next = state;
        cmd_d      = CMD_IDLE;
        edges_d    = edges_q;
        level_d    = level_q;
        seq_d      = seq_q;
        case (state)
            // Stays one cycle idle-on-bus out of reset, then issues the mask write once.
            ST_INIT:   state_next = cmd_q.chipselect ? ST_IDLE : ST_INIT;
            ST_IDLE:   if (bus.irq) state_next = ST_RD_CAP;
            ST_RD_CAP: if (rd_last_c) begin
                           edges_d    = cap_edges_c;
                           state_next = (cap_edges_c == '0) ? ST_IDLE : ST_WR_CLR;
                       end
            ST_WR_CLR: state_next = ST_RD_LVL;
            ST_RD_LVL: if (rd_last_c) begin
                           level_d    = bus.avm_readdata[KEY_W-1:0];
                           state_next = ST_EMIT;
                       end
            ST_EMIT:   if (bus.evt_ready) begin
                           seq_d      = seq_q + SEQ_W'(1);
                           state_next = ST_IDLE;
                       end
            default:   state_next = ST_INIT;
        endcase

        case (state_next)
            ST_INIT:   cmd_d = avm_cmd(OFS_MASK, 1'b1, DATA_W'(IRQ_MASK));
            ST_RD_CAP: cmd_d = avm_cmd(OFS_EDGE, 1'b0, '0);
            ST_WR_CLR: cmd_d = avm_cmd(OFS_EDGE, 1'b1, '0);
            ST_RD_LVL: cmd_d = avm_cmd(OFS_DATA, 1'b0, '0);
            default:   cmd_d = CMD_IDLE;
        endcase

        valid_d = (state_next == ST_EMIT);
        busy_d  = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_INIT;
            cmd_q   <= CMD_IDLE;
            edges_q <= '0;
            level_q <= '0;
            seq_q   <= '0;
            valid_q <= 1'b0;
            busy    <= 1'b1;
        end else begin
            state   <= state_next;
            cmd_q   <= cmd_d;
            edges_q <= edges_d;
            level_q <= level_d;
            seq_q   <= seq_d;
            valid_q <= valid_d;
            busy    <= busy_d;
        end
    end

    assign bus.avm_address    = cmd_q.address;
    assign bus.avm_chipselect = cmd_q.chipselect;
    assign bus.avm_write_n    = cmd_q.write_n;
    assign bus.avm_writedata  = cmd_q.writedata;
    assign bus.evt_valid      = valid_q;
    assign bus.evt_edges      = edges_q;
    assign bus.evt_level      = level_q;
    assign bus.evt_seq        = seq_q;

endmodule

// File: tb/tb_soc_system_key_irq_master.sv
// Bench for soc_system_key_irq_master: key PIO model, directed scenarios and a
// randomized run scored against events derived from observed PIO transactions.
module tb_soc_system_key_irq_master;
    import soc_system_key_irq_master_pkg::*;

    typedef struct packed {
        logic [3:0] edges;
        logic [3:0] level;
        logic [7:0] seq;
    } evt_t;

    localparam logic [53:0] RST_SNAP  = {1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0};
    localparam logic [53:0] INIT_SNAP = {1'b0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd2, 32'hF};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy, busy3;
    always #5 clk = ~clk;

    soc_system_key_irq_master_if u_if ();
    soc_system_key_irq_master_if u_if3 ();

    soc_system_key_irq_master #(.IRQ_MASK(4'hF), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .bus(u_if.master), .busy(busy));

    soc_system_key_irq_master #(.IRQ_MASK(4'h3), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .bus(u_if3.master), .busy(busy3));

    // Key PIO model: active-low keys, falling-edge capture, write to offset 3 clears.
    logic [3:0] keys = 4'hF, keys_q = 4'hF, cap = 4'h0, pio_mask = 4'h0;
    logic       irq_force = 1'b0;
    wire        pio_wr = u_if.avm_chipselect && !u_if.avm_write_n;

    always @(posedge clk) begin
        keys_q <= keys;
        if (pio_wr && u_if.avm_address == OFS_MASK) pio_mask <= u_if.avm_writedata[3:0];
        cap <= ((pio_wr && u_if.avm_address == OFS_EDGE) ? 4'h0 : cap) | (keys_q & ~keys);
    end

    assign u_if.avm_readdata = (u_if.avm_address == OFS_EDGE) ? {28'h0, cap} :
                               (u_if.avm_address == OFS_DATA) ? {28'h0, keys} :
                               (u_if.avm_address == OFS_MASK) ? {28'h0, pio_mask} : 32'h0;
    assign u_if.irq = (|(cap & pio_mask)) | irq_force;
    assign u_if3.avm_readdata = 32'h0000_0005;

    // Transaction monitor: bus access log and expected events built from PIO reads.
    evt_t       exp_q[$];
    logic [2:0] acc_log[$];
    logic [3:0] mon_edges = 4'h0;
    logic [7:0] mon_seq = 8'h00;

    always @(posedge clk) begin
        if (reset) begin
            mon_seq <= 8'h00;
            exp_q.delete();
        end else if (u_if.avm_chipselect) begin
            acc_log.push_back({u_if.avm_write_n, u_if.avm_address});
            if (u_if.avm_write_n && u_if.avm_address == OFS_EDGE)
                mon_edges <= u_if.avm_readdata[3:0] & 4'hF;
            else if (u_if.avm_write_n && u_if.avm_address == OFS_DATA) begin
                exp_q.push_back({mon_edges, u_if.avm_readdata[3:0], mon_seq});
                mon_seq <= mon_seq + 8'd1;
            end
        end
    end

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_seq = 8'h00;

    function automatic logic [53:0] snap();
        return {u_if.evt_valid, u_if.evt_edges, u_if.evt_level, u_if.evt_seq, busy,
                u_if.avm_chipselect, u_if.avm_write_n, u_if.avm_address, u_if.avm_writedata};
    endfunction

    task automatic wait_valid(input int limit, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            n++;
            if (u_if.evt_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (snap() !== RST_SNAP) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", snap(), RST_SNAP);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (snap() !== INIT_SNAP) begin
            errors++;
            $display("FAIL init_write: got %h expected %h", snap(), INIT_SNAP);
        end
        checks++;
        if (u_if3.avm_writedata !== 32'h3 || u_if3.avm_address !== OFS_MASK) begin
            errors++;
            $display("FAIL init_write_mask3: got addr %0d data %h expected addr 2 data 3",
                     u_if3.avm_address, u_if3.avm_writedata);
        end
        @(negedge clk);
        checks++;
        if ({u_if.avm_chipselect, u_if.avm_write_n, u_if.avm_address, u_if.avm_writedata, busy}
            !== {1'b0, 1'b1, 2'd0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL idle_after_init: cs %b wn %b addr %0d busy %b expected 0 1 0 0",
                     u_if.avm_chipselect, u_if.avm_write_n, u_if.avm_address, busy);
        end
        exp_seq = 8'h00;
    endtask

    task automatic test_key_event();
        int  n;
        bit  ok, irq_seen;
        u_if.evt_ready = 1'b1;
        acc_log.delete();
        keys = 4'b1011;
        irq_seen = 1'b0;
        for (int i = 0; i < 10 && !irq_seen; i++) begin
            @(negedge clk);
            irq_seen = u_if.irq;
        end
        wait_valid(20, n, ok);
        checks++;
        if (!irq_seen || !ok || n != 4) begin
            errors++;
            $display("FAIL event_latency: irq %b valid %b cycles %0d expected 4", irq_seen, ok, n);
        end
        checks++;
        if ({u_if.evt_edges, u_if.evt_level, u_if.evt_seq} !== {4'b0100, 4'b1011, 8'h00}) begin
            errors++;
            $display("FAIL event1: edges %b level %b seq %0d expected 0100 1011 0",
                     u_if.evt_edges, u_if.evt_level, u_if.evt_seq);
        end
        checks++;
        if (acc_log.size() != 3 || acc_log[0] !== 3'b111 || acc_log[1] !== 3'b011 ||
            acc_log[2] !== 3'b100) begin
            errors++;
            $display("FAIL bus_sequence: %0d accesses, expected rd3 wr3 rd0", acc_log.size());
        end
        exp_seq++;
        keys = 4'hF;
        repeat (3) @(negedge clk);
        keys = 4'b1011;
        wait_valid(20, n, ok);
        checks++;
        if (!ok || {u_if.evt_edges, u_if.evt_level, u_if.evt_seq} !== {4'b0100, 4'b1011, exp_seq}) begin
            errors++;
            $display("FAIL event2: valid %b edges %b level %b seq %0d expected 0100 1011 %0d",
                     ok, u_if.evt_edges, u_if.evt_level, u_if.evt_seq, exp_seq);
        end
        exp_seq++;
        keys = 4'hF;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_spurious();
        bit saw_valid = 1'b0;
        acc_log.delete();
        irq_force = 1'b1;
        @(negedge clk);
        irq_force = 1'b0;
        repeat (10) begin
            @(negedge clk);
            saw_valid |= u_if.evt_valid;
        end
        checks++;
        if (acc_log.size() != 1 || acc_log[0] !== 3'b111) begin
            errors++;
            $display("FAIL spurious_bus: %0d accesses, expected one read at 3", acc_log.size());
        end
        checks++;
        if (saw_valid || busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_no_event: valid seen %b busy %b expected 0 0", saw_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int          n;
        bit          ok;
        logic [15:0] held;
        u_if.evt_ready = 1'b0;
        keys = 4'b0111;
        wait_valid(20, n, ok);
        checks++;
        if (!ok || {u_if.evt_edges, u_if.evt_level, u_if.evt_seq} !== {4'b1000, 4'b0111, exp_seq}) begin
            errors++;
            $display("FAIL bp_event: valid %b edges %b level %b seq %0d expected 1000 0111 %0d",
                     ok, u_if.evt_edges, u_if.evt_level, u_if.evt_seq, exp_seq);
        end
        held = {4'b1000, 4'b0111, exp_seq};
        acc_log.delete();
        for (int i = 0; i < 20; i++) begin
            keys[0] = ~keys[0];
            @(negedge clk);
            checks++;
            if (!u_if.evt_valid || u_if.avm_chipselect ||
                {u_if.evt_edges, u_if.evt_level, u_if.evt_seq} !== held) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid %b cs %b payload %h expected 1 0 %h",
                         i, u_if.evt_valid, u_if.avm_chipselect,
                         {u_if.evt_edges, u_if.evt_level, u_if.evt_seq}, held);
            end
        end
        checks++;
        if (acc_log.size() != 0) begin
            errors++;
            $display("FAIL bp_no_bus: %0d accesses during stall, expected 0", acc_log.size());
        end
        u_if.evt_ready = 1'b1;
        exp_seq++;
        wait_valid(20, n, ok);
        checks++;
        if (!ok || {u_if.evt_edges, u_if.evt_level, u_if.evt_seq} !== {4'b0001, 4'b0111, exp_seq}) begin
            errors++;
            $display("FAIL bp_second: valid %b edges %b level %b seq %0d expected 0001 0111 %0d",
                     ok, u_if.evt_edges, u_if.evt_level, u_if.evt_seq, exp_seq);
        end
        exp_seq++;
        keys = 4'hF;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_seq_wrap();
        int         n;
        bit         ok;
        bit         saw_wrap = 1'b0;
        logic [7:0] prev = 8'h00;
        u_if.evt_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            keys[1] = 1'b0;
            wait_valid(20, n, ok);
            checks++;
            if (!ok || u_if.evt_seq !== exp_seq) begin
                errors++;
                $display("FAIL wrap_seq event %0d: valid %b seq %0d expected %0d",
                         i, ok, u_if.evt_seq, exp_seq);
            end
            if (i > 0 && prev == 8'hFF && u_if.evt_seq == 8'h00) saw_wrap = 1'b1;
            prev = u_if.evt_seq;
            exp_seq++;
            keys[1] = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!saw_wrap) begin
            errors++;
            $display("FAIL wrap_seen: got 0 expected 1");
        end
    endtask

    task automatic test_random();
        evt_t got;
        int   n_evt = 0;
        exp_q.delete();
        for (int c = 0; c < 450; c++) begin
            @(negedge clk);
            if (c < 400) begin
                if ($urandom_range(7) == 0) keys[$urandom_range(3)] ^= 1'b1;
                u_if.evt_ready = 1'($urandom_range(1));
            end else begin
                u_if.evt_ready = 1'b1;
            end
            if (u_if.evt_valid) begin
                checks++;
                if (u_if.avm_chipselect) begin
                    errors++;
                    $display("FAIL rand_bus_in_emit: cs %b expected 0", u_if.avm_chipselect);
                end
            end
            if (u_if.evt_valid && u_if.evt_ready) begin
                checks++;
                n_evt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected: event %h with no expected event",
                             {u_if.evt_edges, u_if.evt_level, u_if.evt_seq});
                end else begin
                    got = exp_q.pop_front();
                    if ({u_if.evt_edges, u_if.evt_level, u_if.evt_seq} !== got) begin
                        errors++;
                        $display("FAIL rand_event: got %h expected %h",
                                 {u_if.evt_edges, u_if.evt_level, u_if.evt_seq}, got);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0 || n_evt == 0) begin
            errors++;
            $display("FAIL rand_drain: pending %0d busy %b events %0d expected 0 0 >0",
                     exp_q.size(), busy, n_evt);
        end
        keys = 4'hF;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok, hit = 1'b0;
        u_if.evt_ready = 1'b1;
        keys = 4'b1110;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            hit = pio_wr && u_if.avm_address == OFS_EDGE;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (!hit || snap() !== RST_SNAP) begin
            errors++;
            $display("FAIL rst_in_wrclr: found %b got %h expected %h", hit, snap(), RST_SNAP);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (snap() !== INIT_SNAP) begin
            errors++;
            $display("FAIL rst_wrclr_init: got %h expected %h", snap(), INIT_SNAP);
        end
        keys = 4'hF;
        repeat (3) @(negedge clk);
        u_if.evt_ready = 1'b0;
        keys = 4'b1110;
        wait_valid(20, n, ok);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (!ok || snap() !== RST_SNAP) begin
            errors++;
            $display("FAIL rst_in_emit: reached %b got %h expected %h", ok, snap(), RST_SNAP);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (snap() !== INIT_SNAP) begin
            errors++;
            $display("FAIL rst_emit_init: got %h expected %h", snap(), INIT_SNAP);
        end
        keys = 4'hF;
        u_if.evt_ready = 1'b1;
        exp_seq = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_latency_rdlat3();
        int n = 0;
        bit ok = 1'b0;
        u_if3.irq = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            n++;
            u_if3.irq = 1'b0;
            ok = u_if3.evt_valid;
        end
        checks++;
        if (!ok || n != 8) begin
            errors++;
            $display("FAIL rdlat3_latency: valid %b cycles %0d expected 8", ok, n);
        end
        checks++;
        if ({u_if3.evt_edges, u_if3.evt_level, u_if3.evt_seq} !== {4'b0001, 4'b0101, 8'h00}) begin
            errors++;
            $display("FAIL rdlat3_event: edges %b level %b seq %0d expected 0001 0101 0",
                     u_if3.evt_edges, u_if3.evt_level, u_if3.evt_seq);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.evt_ready  = 1'b0;
        u_if3.evt_ready = 1'b1;
        u_if3.irq       = 1'b0;
        test_reset();
        test_key_event();
        test_spurious();
        test_backpressure();
        test_seq_wrap();
        test_random();
        test_reset_mid();
        test_latency_rdlat3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
